// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive/transmit blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int unsigned MIN_BAUD = 4;

endpackage

// File: rtl/uart_baud_tmr.sv
// Loadable bit-period down-counter: half-period load at start detect, then a tick
// every baud_cnt cycles while run is high.
module uart_baud_tmr #(
  parameter int unsigned BAUD_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_half,
  input  logic              run,
  input  logic [BAUD_W-1:0] baud_cnt,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt_q;

  assign tick = run && !load_half && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_half) begin
      cnt_q <= baud_cnt >> 1;
    end else if (run) begin
      cnt_q <= (cnt_q == '0) ? baud_cnt - 1'b1 : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable width/stop bits, runtime parity and baud divisor,
// reporting parity, framing and overrun errors through a rdy/clr_rdy handshake.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned BAUD_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic [BAUD_W-1:0]    baud_cnt,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  uart_rx_state_t state_q, state_d;

  logic                 rx_meta_q, rxs_q;
  logic [BAUD_W-1:0]    baud_in, baud_q, baud_sel;
  logic                 par_en_q, par_odd_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 frm_acc_q;
  logic                 start_det, tick, stop_last, done;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rdy_q, par_err_q, frm_err_q, ovr_err_q;

  // Divisors below the minimum would leave no room for a mid-bit sample.
  assign baud_in   = (baud_cnt < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : baud_cnt;
  assign start_det = (state_q == IDLE) && !rxs_q;
  assign baud_sel  = start_det ? baud_in : baud_q;
  assign stop_last = (STOP_BITS == 1) || stop_cnt_q;

  uart_baud_tmr #(
    .BAUD_W (BAUD_W)
  ) u_baud_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_half (start_det),
    .run       (state_q != IDLE),
    .baud_cnt  (baud_sel),
    .tick      (tick)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:   if (!rxs_q) state_d = START;
      START:  if (tick) state_d = rxs_q ? IDLE : DATA;
      DATA:   if (tick && (bit_cnt_q == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (tick) state_d = STOP;
      STOP: begin
        if (tick && stop_last) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      baud_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      frm_acc_q  <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      if (start_det) begin
        baud_q     <= baud_in;
        par_en_q   <= par_en;
        par_odd_q  <= par_odd;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        frm_acc_q  <= 1'b0;
      end
      if (tick) begin
        if (state_q == DATA) begin
          shift_q   <= {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        if (state_q == PARITY) par_bit_q <= rxs_q;
        if (state_q == STOP) begin
          frm_acc_q  <= frm_acc_q | ~rxs_q;
          stop_cnt_q <= 1'b1;
        end
      end
    end
  end

  // Completion takes priority over a coincident clr_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else if (done) begin
      rx_data_q <= shift_q;
      par_err_q <= par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
      frm_err_q <= frm_acc_q | ~rxs_q;
      rdy_q     <= 1'b1;
      if (rdy_q && !clr_rdy) ovr_err_q <= 1'b1;
    end else if (clr_rdy) begin
      rdy_q     <= 1'b0;
      ovr_err_q <= 1'b0;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1-default instance and a 7-bit/2-stop instance, checked
// every cycle against a frame-level model plus directed literal expectations.
module tb_uart_rx_cfg;

  localparam int unsigned BW = 13;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [1:0]    rx      = 2'b11;
  logic [BW-1:0] baud    = 13'd16;
  logic          par_en  = 1'b0;
  logic          par_odd = 1'b0;
  logic          clr_rdy = 1'b0;
  logic [7:0]    dat0;
  logic [6:0]    dat1;
  logic [1:0]    rdy_o, par_o, frm_o, ovr_o, busy_o;

  int db [2] = '{8, 7};
  int sb [2] = '{1, 2};

  uart_rx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .BAUD_W(BW)) dut0 (
    .clk(clk), .rst_n(rst_n), .RX(rx[0]), .baud_cnt(baud), .par_en(par_en),
    .par_odd(par_odd), .clr_rdy(clr_rdy), .rx_data(dat0), .rdy(rdy_o[0]),
    .par_err(par_o[0]), .frm_err(frm_o[0]), .ovr_err(ovr_o[0]), .busy(busy_o[0])
  );

  uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2), .BAUD_W(BW)) dut1 (
    .clk(clk), .rst_n(rst_n), .RX(rx[1]), .baud_cnt(baud), .par_en(par_en),
    .par_odd(par_odd), .clr_rdy(clr_rdy), .rx_data(dat1), .rdy(rdy_o[1]),
    .par_err(par_o[1]), .frm_err(frm_o[1]), .ovr_err(ovr_o[1]), .busy(busy_o[1])
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  logic   clr_e = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_e <= clr_rdy;
  end

  typedef struct {
    longint due;
    int     d;
    int     data;
    bit     pe;
    bit     fe;
  } ev_t;

  ev_t evq[$];
  int  m_dat [2];
  bit  m_rdy [2];
  bit  m_par [2];
  bit  m_frm [2];
  bit  m_ovr [2];
  int  total = 0;
  int  bad   = 0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Frame-level model: each queued frame lands on its predicted completion cycle.
  always @(negedge clk) begin
    logic [1:0] hit;
    int         dd;
    hit = '0;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_dat[k] = 0; m_rdy[k] = 0; m_par[k] = 0; m_frm[k] = 0; m_ovr[k] = 0;
      end
      evq.delete();
    end else begin
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].due == cyc) begin
          dd      = evq[i].d;
          hit[dd] = 1'b1;
          if (m_rdy[dd] && !clr_e) m_ovr[dd] = 1;
          m_rdy[dd] = 1;
          m_dat[dd] = evq[i].data;
          m_par[dd] = evq[i].pe;
          m_frm[dd] = evq[i].fe;
          evq.delete(i);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (!hit[k] && clr_e) begin
          m_rdy[k] = 0;
          m_ovr[k] = 0;
        end
      end
    end
    check("rdy0", int'(rdy_o[0]), int'(m_rdy[0]));
    check("data0", int'(dat0), m_dat[0]);
    check("par0", int'(par_o[0]), int'(m_par[0]));
    check("frm0", int'(frm_o[0]), int'(m_frm[0]));
    check("ovr0", int'(ovr_o[0]), int'(m_ovr[0]));
    check("rdy1", int'(rdy_o[1]), int'(m_rdy[1]));
    check("data1", int'(dat1), m_dat[1]);
    check("par1", int'(par_o[1]), int'(m_par[1]));
    check("frm1", int'(frm_o[1]), int'(m_frm[1]));
    check("ovr1", int'(ovr_o[1]), int'(m_ovr[1]));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_cyc(input longint t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    idle(1);
    clr_rdy = 1'b0;
  endtask

  // Sync (2) + start detect (1) + half bit + n_f whole bits + 1 register stage.
  task automatic send_frame(input int d, input int data, input bit pe, input bit po,
                            input bit flip_par, input int stop_low, input bit clr_done);
    int  bits[$];
    int  ones;
    int  b;
    bit  pbit;
    bit  fe;
    ev_t ev;
    par_en  = pe;
    par_odd = po;
    b       = int'(baud);
    ones    = 0;
    fe      = 0;
    bits.push_back(0);
    for (int i = 0; i < db[d]; i++) begin
      bits.push_back((data >> i) & 1);
      ones += (data >> i) & 1;
    end
    pbit = ((ones % 2) != 0) ^ po ^ flip_par;
    if (pe) bits.push_back(int'(pbit));
    for (int s = 0; s < sb[d]; s++) begin
      bits.push_back(((stop_low >> s) & 1) != 0 ? 0 : 1);
      if (((stop_low >> s) & 1) != 0) fe = 1;
    end
    ev.due  = cyc + 4 + (b / 2) + longint'(bits.size() - 1) * b;
    ev.d    = d;
    ev.data = data & ((1 << db[d]) - 1);
    ev.pe   = pe && ((((ones + int'(pbit)) % 2) != 0) != po);
    ev.fe   = fe;
    evq.push_back(ev);
    foreach (bits[k]) begin
      rx[d] = (bits[k] != 0);
      repeat (b) begin
        @(posedge clk);
        #1;
        if (clr_done) clr_rdy = (cyc == ev.due - 1);
      end
    end
    rx[d] = 1'b1;
    if (clr_done) begin
      while (cyc <= ev.due) begin
        @(posedge clk);
        #1;
        clr_rdy = (cyc == ev.due - 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    longint c0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rdy", int'(rdy_o[0]), 0);
    check("reset_busy0", int'(busy_o[0]), 0);
    check("reset_busy1", int'(busy_o[1]), 0);
    @(posedge clk);
    #1;

    // 8N1 0xA5 at baud 16: completion lands 156 cycles after the start edge.
    c0 = cyc;
    fork
      send_frame(0, 'hA5, 0, 0, 0, 0, 0);
      begin
        at_cyc(c0 + 155);
        check("a5_rdy_before", int'(rdy_o[0]), 0);
        at_cyc(c0 + 156);
        check("a5_rdy", int'(rdy_o[0]), 1);
        check("a5_data", int'(dat0), 'hA5);
        check("a5_par", int'(par_o[0]), 0);
        check("a5_frm", int'(frm_o[0]), 0);
      end
    join
    idle(20);

    // Even parity on 0x37 needs parity bit 1.
    send_frame(0, 'h37, 1, 0, 1, 0, 0);
    idle(20);
    check("par_bad_data", int'(dat0), 'h37);
    check("par_bad_flag", int'(par_o[0]), 1);
    send_frame(0, 'h37, 1, 0, 0, 0, 0);
    idle(20);
    check("par_ok_flag", int'(par_o[0]), 0);

    send_frame(0, 'h5A, 0, 0, 0, 1, 0);
    idle(32);
    check("frm_flag", int'(frm_o[0]), 1);
    check("frm_rdy", int'(rdy_o[0]), 1);
    check("frm_data", int'(dat0), 'h5A);

    send_frame(1, 'h2B, 0, 0, 0, 2, 0);
    idle(32);
    check("stop2_frm", int'(frm_o[1]), 1);
    check("stop2_data", int'(dat1), 'h2B);

    // False start: 5-cycle low pulse is gone by the mid-start sample.
    c0 = cyc;
    rx[0] = 1'b0;
    idle(5);
    rx[0] = 1'b1;
    at_cyc(c0 + 5);
    check("false_busy_hi", int'(busy_o[0]), 1);
    at_cyc(c0 + 14);
    check("false_busy_lo", int'(busy_o[0]), 0);
    check("false_data", int'(dat0), 'h5A);
    @(posedge clk);
    #1;
    idle(20);

    pulse_clr();
    send_frame(0, 'h11, 0, 0, 0, 0, 0);
    send_frame(0, 'h22, 0, 0, 0, 0, 0);
    idle(20);
    check("ovr_data", int'(dat0), 'h22);
    check("ovr_flag", int'(ovr_o[0]), 1);
    pulse_clr();
    @(negedge clk);
    check("clr_rdy", int'(rdy_o[0]), 0);
    check("clr_ovr", int'(ovr_o[0]), 0);
    @(posedge clk);
    #1;
    send_frame(0, 'h33, 0, 0, 0, 0, 0);
    send_frame(0, 'h44, 0, 0, 0, 0, 1);
    idle(20);
    check("coinc_rdy", int'(rdy_o[0]), 1);
    check("coinc_ovr", int'(ovr_o[0]), 0);
    check("coinc_data", int'(dat0), 'h44);

    // Reset in the middle of the data bits.
    rx[0] = 1'b0;
    idle(64);
    @(negedge clk);
    check("mid_busy", int'(busy_o[0]), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy_o[0]), 0);
    check("rst_rdy", int'(rdy_o[0]), 0);
    check("rst_data", int'(dat0), 0);
    @(posedge clk);
    #1;
    idle(3);
    rx[0] = 1'b1;
    rst_n = 1'b1;
    idle(32);
    send_frame(0, 'hC3, 0, 0, 0, 0, 0);
    idle(20);
    check("post_rst_data", int'(dat0), 'hC3);

    send_frame(1, 'h55, 0, 0, 0, 0, 0);
    idle(40);
    check("w7_data", int'(dat1), 'h55);

    for (int n = 0; n < 60; n++) begin
      int d;
      int b;
      int sl;
      bit last_low;
      d    = int'($urandom_range(0, 1));
      b    = int'($urandom_range(4, 40));
      baud = BW'(b);
      sl   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, (1 << sb[d]) - 1)) : 0;
      last_low = ((sl >> (sb[d] - 1)) & 1) != 0;
      send_frame(d, int'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), sl, $urandom_range(0, 4) == 0);
      if (last_low) idle(2 * b);
      else idle(int'($urandom_range(0, b)));
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end
    idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver that supports configurable data width and stop-bit count, runtime-selectable parity and a runtime baud divisor. It rejects false start bits and reports parity, framing and overrun errors. The block sits between the synchronised serial input pin and the command/packet layer, and its rdy/clr_rdy handshake is the one the team's existing consumers use.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
STOP_BITS, 1, stop bits expected (1 or 2)
BAUD_W, 13, width of baud_cnt

Ports:
clk  in  1  clock
rst_n  in  1  reset
RX  in  1  asynchronous serial input, idle high
baud_cnt  in  BAUD_W  bit period in clk cycles; minimum 4
par_en  in  1  1 = one parity bit follows the data bits
par_odd  in  1  1 = odd parity, 0 = even parity (used only when par_en=1)
clr_rdy  in  1  consumer acknowledge; clears rdy and ovr_err
rx_data  out  DATA_BITS  last received data word
rdy  out  1  a frame is available
par_err  out  1  parity mismatch on the frame in rx_data
frm_err  out  1  a stop-bit sample was low on the frame in rx_data
ovr_err  out  1  a frame completed while rdy was already 1
busy  out  1  receiver is not in IDLE

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. Reset forces the state to IDLE and both synchroniser flops to 1. All outputs reset to 0.
- RX passes through a 2-flop synchroniser; rxs denotes the synchronised value. All sampling uses rxs.
- Baud timer: loaded with baud_cnt>>1 at start detect and decrements each cycle while busy. At 0 a sample point occurs and the timer reloads baud_cnt-1, so sample points are exactly baud_cnt cycles apart.
- baud_cnt, par_en and par_odd are captured at start detect and held constant for the frame.
- State machine:
  - IDLE: when rxs==0, load the timer, go to START.
  - START: at the sample point, if rxs==1 it is a false start: go to IDLE with no flags changed. Otherwise go to DATA.
  - DATA: shift rxs in LSB first at each sample point. After DATA_BITS samples go to PARITY if par_en, else go to STOP.
  - PARITY: sample one bit, then go to STOP. par_err = (XOR of data bits ^ sampled bit) != par_odd.
  - STOP: take STOP_BITS samples; frm_err=1 if any sample is 0. At the final stop sample go to IDLE.
- Completion: in the cycle after the final stop sample:
  - rx_data, par_err and frm_err are updated and rdy=1.
  - If par_en=0, par_err=0.
  - The receiver is back in IDLE mid-stop-bit, so a back-to-back start is detected without loss.
- Overrun: if rdy==1 at completion and clr_rdy is not asserted that cycle, ovr_err=1 and rx_data is overwritten with the new frame.
- If clr_rdy and completion occur in the same cycle, completion wins: rdy=1 and ovr_err is unchanged.
- clr_rdy clears rdy and ovr_err only. par_err and frm_err persist until the next completion.
- Frames with frm_err or par_err still set rdy.
- busy = (state != IDLE).
- Reset mid-frame aborts the frame. The line must return high before the next start is detected, because the synchroniser resets to 1.

Decomposition:
- Package uart_pkg: enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP}, and constant MIN_BAUD=4.
- Sub-module uart_baud_tmr: loadable down-counter of width BAUD_W. Inputs: load_half, run, baud_cnt. Output: one-cycle tick. Reused later by the transmitter.
- Bit counter and shift register stay in the top module.

Test Plan:
- Defaults, baud_cnt=16, 8N1 frame carrying 0xA5 -> rx_data=0xA5, rdy=1, par_err=0, frm_err=0; rdy rises 1 cycle after the stop sample.
- par_en=1, par_odd=0, data 0x37 with parity bit 0 (correct is 1) -> rx_data=0x37, par_err=1; repeat with parity bit 1 -> par_err=0.
- Stop bit driven 0 on 0x5A -> frm_err=1, rdy=1. With STOP_BITS=2 and the second stop bit low -> frm_err=1.
- RX low pulse of 5 cycles at baud_cnt=16 -> busy pulses, then returns to 0; rdy, rx_data and error flags are unchanged.
- Frames 0x11 then 0x22 back-to-back with no clr_rdy -> rx_data=0x22, ovr_err=1. A clr_rdy pulse -> rdy=0, ovr_err=0. clr_rdy coincident with completion -> rdy=1, ovr_err=0.
- rst_n asserted mid DATA -> all outputs 0 and busy=0; RX held high 2 bit-times, then 0xC3 sent -> rx_data=0xC3. Rerun with DATA_BITS=7 and 0x55 -> rx_data=7'h55.
